// File: rtl/status_pkg.sv
// Shared types for the processor status word: condition codes and flag layout.
package status_pkg;

  localparam int unsigned FLAG_W = 5;

  // Bit positions of each flag inside the {X,Z,N,C,V} word.
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_X = 4;

  typedef enum logic [3:0] {
    CondAlways = 4'h0,
    CondEq     = 4'h1,
    CondNe     = 4'h2,
    CondCs     = 4'h3,
    CondCc     = 4'h4,
    CondMi     = 4'h5,
    CondPl     = 4'h6,
    CondVs     = 4'h7,
    CondVc     = 4'h8,
    CondXs     = 4'h9,
    CondXc     = 4'hA,
    CondGe     = 4'hB,
    CondLt     = 4'hC,
    CondGt     = 4'hD,
    CondLe     = 4'hE,
    CondNever  = 4'hF
  } cond_t;

  // Field order makes x the MSB and v the LSB, matching the FLAG_* indices.
  typedef struct packed {
    logic x;
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator over a registered flag word.
module cond_eval
  import status_pkg::*;
(
  input  cond_t  cond,
  input  flags_t flags,
  output logic   cond_true
);

  // Decode the 4-bit condition code against the supplied flags.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      CondAlways: cond_true = 1'b1;
      CondEq:     cond_true = flags.z;
      CondNe:     cond_true = ~flags.z;
      CondCs:     cond_true = flags.c;
      CondCc:     cond_true = ~flags.c;
      CondMi:     cond_true = flags.n;
      CondPl:     cond_true = ~flags.n;
      CondVs:     cond_true = flags.v;
      CondVc:     cond_true = ~flags.v;
      CondXs:     cond_true = flags.x;
      CondXc:     cond_true = ~flags.x;
      CondGe:     cond_true = (flags.n == flags.v);
      CondLt:     cond_true = (flags.n != flags.v);
      CondGt:     cond_true = ~flags.z & (flags.n == flags.v);
      CondLe:     cond_true = flags.z | (flags.n != flags.v);
      CondNever:  cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_flags.sv
// Registered processor status word with condition evaluation and an
// interrupt shadow stack (LIFO) for flag save/restore.
module status_flags
  import status_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_v,
  input  logic              alu_c,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_x,
  input  logic              alu_set_vc,
  input  logic              flag_we,
  input  logic              status_we,
  input  logic [FLAG_W-1:0] status_in,
  input  logic              irq_save,
  input  logic              irq_restore,
  input  logic              err_clr,
  input  logic [3:0]        cond,
  output logic [FLAG_W-1:0] flags,
  output logic              cond_true,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err_sticky
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t           flags_q, flags_d;
  logic [PTR_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;
  flags_t           stack_q [DEPTH];

  logic             full, empty;
  logic             push_req, pop_req, do_push, do_pop, err_set;
  logic [PTR_W-1:0] occ_m1;
  logic [IDX_W-1:0] push_idx, pop_idx;

  assign full  = (occ_q == PTR_W'(DEPTH));
  assign empty = (occ_q == '0);

  // Save and restore together cancel each other and count as misuse.
  assign push_req = irq_save & ~irq_restore;
  assign pop_req  = irq_restore & ~irq_save;
  assign do_push  = push_req & ~full;
  assign do_pop   = pop_req & ~empty;
  assign err_set  = (irq_save & irq_restore) | (push_req & full) | (pop_req & empty);

  assign occ_m1   = occ_q - PTR_W'(1);
  assign push_idx = occ_q[IDX_W-1:0];
  assign pop_idx  = occ_m1[IDX_W-1:0];

  // Flag-word next state: restore beats status_we beats ALU writeback.
  always_comb begin
    flags_d = flags_q;
    if (do_pop) begin
      flags_d = stack_q[pop_idx];
    end else if (status_we) begin
      flags_d = flags_t'(status_in);
    end else if (flag_we) begin
      flags_d.n = alu_n;
      flags_d.z = alu_z;
      flags_d.x = alu_x;
      if (alu_set_vc) begin
        flags_d.v = alu_v;
        flags_d.c = alu_c;
      end
    end
  end

  // Occupancy and sticky-error next state; a new error wins over err_clr.
  always_comb begin
    occ_d = occ_q;
    if (do_push) begin
      occ_d = occ_q + PTR_W'(1);
    end else if (do_pop) begin
      occ_d = occ_m1;
    end
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Status state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  // Shadow stack storage; pushes capture the pre-update flag word.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_q[push_idx] <= flags_q;
    end
  end

  cond_eval u_cond_eval (
    .cond      (cond_t'(cond)),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  assign flags       = flags_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign err_sticky  = err_q;

endmodule

// File: doc/status_flags.md
Name: status_flags

Overview:
- Registered processor status word; the consuming end of the ALU flag outputs (V, C, N, Z, X, set_VC).
- Latches flags on ALU writeback, evaluates 4-bit branch condition codes against the registered flags, and keeps a LIFO shadow stack for interrupt entry and return.
- Sits between the ALU and the control unit / PC-select logic.

Parameters:
- DEPTH, 4, number of shadow-stack entries (1..8).
- PTR_W, $clog2(DEPTH+1), width of the stack occupancy counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- alu_v, alu_c, alu_n, alu_z, alu_x  in  1 each  ALU flag outputs.
- alu_set_vc  in  1  ALU indication that V and C are meaningful.
- flag_we  in  1  latch ALU flags this cycle.
- status_we  in  1  load the flag word from status_in (move-to-status instruction).
- status_in  in  5  flag word {X,Z,N,C,V}.
- irq_save  in  1  push the current flag word onto the shadow stack.
- irq_restore  in  1  pop the shadow stack into the flag word.
- err_clr  in  1  clear err_sticky.
- cond  in  4  condition code to evaluate.
- flags  out  5  registered flag word {X,Z,N,C,V}.
- cond_true  out  1  selected condition holds on the current registered flags.
- stack_full  out  1  occupancy == DEPTH.
- stack_empty  out  1  occupancy == 0.
- err_sticky  out  1  a stack misuse has occurred since the last clear.

Behaviour:
- Reset (reset_n low at a clock edge): flags=0, occupancy=0, err_sticky=0, stack contents don't-care. This gives stack_empty=1, stack_full=0, and cond_true=1 only for ALWAYS and for conditions satisfied by all-zero flags.
- flag_we:
  - next N, Z, X take alu_n, alu_z, alu_x.
  - V and C take alu_v, alu_c only when alu_set_vc=1; otherwise they keep their old values.
- Flag-word write priority, highest first:
  - valid restore (stack non-empty, no save this cycle);
  - status_we;
  - flag_we.
  - Lower-priority writes in the same cycle are discarded.
- irq_save:
  - Pushes the registered flags as they were before this edge. A flag_we in the same cycle still updates flags, so the pre-update value is the one saved.
  - On a push, stack[occupancy] gets flags and occupancy increments.
- irq_restore: on a pop, occupancy decrements and flags take stack[occupancy-1] at the same edge.
- Boundary conditions:
  - Save when full: no push, no overwrite, err_sticky set.
  - Restore when empty: flags follow status_we/flag_we priority as if no restore, err_sticky set.
  - Save and restore together: stack and occupancy unchanged, restore not applied, err_sticky set.
- err_sticky:
  - Set has priority over err_clr in the same cycle.
  - Cleared only by err_clr or reset.
- Latency:
  - Flag updates are visible on flags one cycle after the write strobe.
  - cond_true is purely combinational from cond and the registered flags; there is no bypass of same-cycle ALU flags.
- Condition codes (cond -> true when):
  - 0 ALWAYS -> 1
  - 1 EQ -> Z
  - 2 NE -> !Z
  - 3 CS -> C
  - 4 CC -> !C
  - 5 MI -> N
  - 6 PL -> !N
  - 7 VS -> V
  - 8 VC -> !V
  - 9 XS -> X
  - A XC -> !X
  - B GE -> N==V
  - C LT -> N!=V
  - D GT -> !Z & (N==V)
  - E LE -> Z | (N!=V)
  - F NEVER -> 0

Decomposition:
- Shared package status_pkg holds:
  - cond_t enum with the 16 codes above;
  - flag bit-index localparams FLAG_V=0, FLAG_C=1, FLAG_N=2, FLAG_Z=3, FLAG_X=4;
  - packed flags_t struct {x,z,n,c,v}.
- One natural sub-module, cond_eval: combinational (cond_t, flags_t) -> cond_true, reused by the future branch predictor.
- The shadow stack stays inline as a register array with an occupancy counter.

Test Plan:
- Reset, then flag_we with alu {v=1,c=1,n=0,z=1,x=0}, set_vc=1 -> next cycle flags=5'b01011; cond=1 true, cond=4 false, cond=D false.
- flags=5'b01011, then flag_we with set_vc=0, alu {v=0,c=0,n=1,z=0,x=1} -> flags=5'b10111 (V and C retained); cond=C (LT) false since N==V.
- flags=5'h03, irq_save plus flag_we (alu all zero, set_vc=1) in the same cycle -> flags=0, occupancy 1; later irq_restore -> flags=5'h03, stack_empty=1.
- DEPTH=4: five saves -> stack_full after the 4th, 5th sets err_sticky, occupancy stays 4; four restores return the values in LIFO order; a 5th restore sets err (after err_clr) and leaves flags unchanged.
- Same cycle: restore (top=5'h1F), status_we with 5'h01, flag_we -> flags=5'h1F; irq_save and irq_restore together -> occupancy unchanged, err_sticky=1.
- reset_n low mid-sequence with occupancy 3 and err_sticky=1 -> next cycle flags=0, stack_empty=1, err_sticky=0.
